// File: rtl/rcc_bdcr_pkg.sv
// Shared BDCR bit layout, field container and write-sequencer state encoding
// for the core-side backup-domain control register access controller.
package rcc_bdcr_pkg;

   localparam int BIT_BDRST    = 16;
   localparam int BIT_RTCEN    = 15;
   localparam int BIT_RTCSEL   = 8;
   localparam int BIT_LSECSSD  = 6;
   localparam int BIT_LSECSSON = 5;
   localparam int BIT_LSEDRV   = 3;
   localparam int BIT_LSEBYP   = 2;
   localparam int BIT_LSERDY   = 1;
   localparam int BIT_LSEON    = 0;

   localparam int RTCSEL_W  = 2;
   localparam int LSEDRV_W  = 2;
   localparam int NUM_BYTES = 3;
   localparam int CNT_W     = 8;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SETUP,
      ST_PULSE,
      ST_HOLD
   } seq_state_t;

   // Writable BDCR fields, i.e. everything the storage block captures.
   typedef struct packed {
      logic                bdrst;
      logic                rtcen;
      logic [RTCSEL_W-1:0] rtcsel;
      logic                lsecsson;
      logic [LSEDRV_W-1:0] lsedrv;
      logic                lsebyp;
      logic                lseon;
   } bdcr_wr_t;

endpackage

// File: rtl/rcc_bdcr_wr_ctrl_if.sv
// Request/response bus between the core and the BDCR access controller.
interface rcc_bdcr_wr_ctrl_if;

   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [31:0] req_wdata;
   logic [3:0]  req_be;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_err;

   modport master (
      output req_valid, req_write, req_wdata, req_be,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err
   );

   modport slave (
      input  req_valid, req_write, req_wdata, req_be,
      output req_ready, rsp_valid, rsp_rdata, rsp_err
   );

endinterface

// File: rtl/rcc_bdcr_pulse_gen.sv
// SETUP/PULSE/HOLD sequencer for one storage write; each phase length is a
// down-counter reloaded on state entry.
module rcc_bdcr_pulse_gen
   import rcc_bdcr_pkg::*;
#(
   parameter int SETUP_CYC = 1,
   parameter int PULSE_CYC = 2,
   parameter int HOLD_CYC  = 1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic start_i,
   output logic busy_o,
   output logic pulse_nxt_o,
   output logic done_o
);

   localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYC - 1);
   localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(PULSE_CYC - 1);
   localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_CYC - 1);

   seq_state_t       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      done_o  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start_i) begin
               state_d = ST_SETUP;
               cnt_d   = SETUP_LD;
            end
         end
         ST_SETUP: begin
            if (cnt_q == '0) begin
               state_d = ST_PULSE;
               cnt_d   = PULSE_LD;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         ST_PULSE: begin
            if (cnt_q == '0) begin
               state_d = ST_HOLD;
               cnt_d   = HOLD_LD;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         ST_HOLD: begin
            if (cnt_q == '0) begin
               state_d = ST_IDLE;
               done_o  = 1'b1;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Look-ahead phase so the parent can register its write strobes.
   assign busy_o      = (state_q != ST_IDLE);
   assign pulse_nxt_o = (state_d == ST_PULSE);

endmodule

// File: rtl/rcc_bdcr_wr_ctrl.sv
// Core-side BDCR access controller: DBP-protected writes with per-field rules,
// registered byte strobes used as storage capture clocks, and image read-back.
module rcc_bdcr_wr_ctrl
   import rcc_bdcr_pkg::*;
#(
   parameter int SETUP_CYC = 1,
   parameter int PULSE_CYC = 2,
   parameter int HOLD_CYC  = 1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                dbp,
   rcc_bdcr_wr_ctrl_if.slave   bus,
   output logic                rcc_bdcr_byte0_wren,
   output logic                rcc_bdcr_byte1_wren,
   output logic                rcc_bdcr_byte2_wren,
   output logic                nxt_rcc_bdcr_bdrst,
   output logic                nxt_rcc_bdcr_rtcen,
   output logic [RTCSEL_W-1:0] nxt_rcc_bdcr_rtcsel,
   output logic                nxt_rcc_bdcr_lsecsson,
   output logic [LSEDRV_W-1:0] nxt_rcc_bdcr_lsedrv,
   output logic                nxt_rcc_bdcr_lsebyp,
   output logic                nxt_rcc_bdcr_lseon,
   input  logic                cur_rcc_bdcr_bdrst,
   input  logic                cur_rcc_bdcr_rtcen,
   input  logic [RTCSEL_W-1:0] cur_rcc_bdcr_rtcsel,
   input  logic                cur_rcc_bdcr_lsecssd,
   input  logic                cur_rcc_bdcr_lsecsson,
   input  logic [LSEDRV_W-1:0] cur_rcc_bdcr_lsedrv,
   input  logic                cur_rcc_bdcr_lsebyp,
   input  logic                cur_rcc_bdcr_lserdy,
   input  logic                cur_rcc_bdcr_lseon
);

   logic                 busy, pulse_nxt, done, accept, start;
   logic [NUM_BYTES-1:0] mask_q, mask_d, wren_q, wren_d;
   bdcr_wr_t             nxt_q, nxt_d, cur_f;
   logic                 rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;
   logic [31:0]          rdata_q, rdata_d, image;
   logic                 unused_bits;

   rcc_bdcr_pulse_gen #(
      .SETUP_CYC (SETUP_CYC),
      .PULSE_CYC (PULSE_CYC),
      .HOLD_CYC  (HOLD_CYC)
   ) u_pulse_gen (
      .clk         (clk),
      .rst_n       (rst_n),
      .start_i     (start),
      .busy_o      (busy),
      .pulse_nxt_o (pulse_nxt),
      .done_o      (done)
   );

   assign cur_f = {cur_rcc_bdcr_bdrst, cur_rcc_bdcr_rtcen, cur_rcc_bdcr_rtcsel,
                   cur_rcc_bdcr_lsecsson, cur_rcc_bdcr_lsedrv, cur_rcc_bdcr_lsebyp,
                   cur_rcc_bdcr_lseon};

   assign bus.req_ready = ~busy;
   assign accept        = bus.req_valid & ~busy;

   always_comb begin
      image                           = '0;
      image[BIT_BDRST]                = cur_rcc_bdcr_bdrst;
      image[BIT_RTCEN]                = cur_rcc_bdcr_rtcen;
      image[BIT_RTCSEL +: RTCSEL_W]   = cur_rcc_bdcr_rtcsel;
      image[BIT_LSECSSD]              = cur_rcc_bdcr_lsecssd;
      image[BIT_LSECSSON]             = cur_rcc_bdcr_lsecsson;
      image[BIT_LSEDRV +: LSEDRV_W]   = cur_rcc_bdcr_lsedrv;
      image[BIT_LSEBYP]               = cur_rcc_bdcr_lsebyp;
      image[BIT_LSERDY]               = cur_rcc_bdcr_lserdy;
      image[BIT_LSEON]                = cur_rcc_bdcr_lseon;
   end

   always_comb begin
      nxt_d       = nxt_q;
      mask_d      = mask_q;
      start       = 1'b0;
      rsp_valid_d = done;
      rsp_err_d   = 1'b0;
      rdata_d     = '0;
      if (accept) begin
         if (!bus.req_write) begin
            rsp_valid_d = 1'b1;
            rdata_d     = image;
         end else if (!dbp) begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
         end else if (bus.req_be[2:0] == 3'b000) begin
            rsp_valid_d = 1'b1;
         end else begin
            start  = 1'b1;
            mask_d = bus.req_be[2:0];
            // Bytes not enabled keep the current values; storage is not clocked for them.
            nxt_d  = cur_f;
            if (bus.req_be[0]) begin
               nxt_d.lseon    = bus.req_wdata[BIT_LSEON];
               nxt_d.lsecsson = bus.req_wdata[BIT_LSECSSON] | cur_rcc_bdcr_lsecsson;
               if (!cur_rcc_bdcr_lseon) begin
                  nxt_d.lsedrv = bus.req_wdata[BIT_LSEDRV +: LSEDRV_W];
                  nxt_d.lsebyp = bus.req_wdata[BIT_LSEBYP];
               end
            end
            if (bus.req_be[1]) begin
               nxt_d.rtcen  = bus.req_wdata[BIT_RTCEN];
               nxt_d.rtcsel = bus.req_wdata[BIT_RTCSEL +: RTCSEL_W];
            end
            if (bus.req_be[2]) begin
               nxt_d.bdrst = bus.req_wdata[BIT_BDRST];
            end
         end
      end
   end

   assign wren_d = pulse_nxt ? mask_q : '0;

   // Strobes act as storage clocks, so they leave only from flops.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         nxt_q       <= '0;
         mask_q      <= '0;
         wren_q      <= '0;
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         rdata_q     <= '0;
      end else begin
         nxt_q       <= nxt_d;
         mask_q      <= mask_d;
         wren_q      <= wren_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_err_q   <= rsp_err_d;
         rdata_q     <= rdata_d;
      end
   end

   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_err   = rsp_err_q;
   assign bus.rsp_rdata = rdata_q;

   assign rcc_bdcr_byte0_wren   = wren_q[0];
   assign rcc_bdcr_byte1_wren   = wren_q[1];
   assign rcc_bdcr_byte2_wren   = wren_q[2];
   assign nxt_rcc_bdcr_bdrst    = nxt_q.bdrst;
   assign nxt_rcc_bdcr_rtcen    = nxt_q.rtcen;
   assign nxt_rcc_bdcr_rtcsel   = nxt_q.rtcsel;
   assign nxt_rcc_bdcr_lsecsson = nxt_q.lsecsson;
   assign nxt_rcc_bdcr_lsedrv   = nxt_q.lsedrv;
   assign nxt_rcc_bdcr_lsebyp   = nxt_q.lsebyp;
   assign nxt_rcc_bdcr_lseon    = nxt_q.lseon;

   assign unused_bits = ^{bus.req_be[3], bus.req_wdata[31:17], bus.req_wdata[14:10],
                          bus.req_wdata[7:6], bus.req_wdata[1]};

endmodule

// File: tb/tb_rcc_bdcr_wr_ctrl.sv
// Directed bench for the BDCR access controller: scoreboard of expected
// responses plus latency, strobe and field-value checks per transaction.
module tb_rcc_bdcr_wr_ctrl;

   logic       clk   = 1'b0;
   logic       rst_n = 1'b1;
   logic       dbp   = 1'b0;
   logic       wren0, wren1, wren2;
   logic       n_bdrst, n_rtcen, n_lsecsson, n_lsebyp, n_lseon;
   logic [1:0] n_rtcsel, n_lsedrv;
   logic       c_bdrst = 1'b0, c_rtcen = 1'b0, c_lsecssd = 1'b0, c_lsecsson = 1'b0;
   logic       c_lsebyp = 1'b0, c_lserdy = 1'b0, c_lseon = 1'b0;
   logic [1:0] c_rtcsel = 2'b00, c_lsedrv = 2'b00;
   logic [8:0] nxt_vec;
   logic [2:0] wren_vec;

   int          checks = 0;
   int          failures = 0;
   logic [32:0] exp_q[$];
   logic [32:0] mon_e;

   int         lat, n0, n1, n2, first, waited, rsp_cnt;
   logic [8:0] nr;

   rcc_bdcr_wr_ctrl_if bus ();

   rcc_bdcr_wr_ctrl dut (
      .clk                   (clk),
      .rst_n                 (rst_n),
      .dbp                   (dbp),
      .bus                   (bus),
      .rcc_bdcr_byte0_wren   (wren0),
      .rcc_bdcr_byte1_wren   (wren1),
      .rcc_bdcr_byte2_wren   (wren2),
      .nxt_rcc_bdcr_bdrst    (n_bdrst),
      .nxt_rcc_bdcr_rtcen    (n_rtcen),
      .nxt_rcc_bdcr_rtcsel   (n_rtcsel),
      .nxt_rcc_bdcr_lsecsson (n_lsecsson),
      .nxt_rcc_bdcr_lsedrv   (n_lsedrv),
      .nxt_rcc_bdcr_lsebyp   (n_lsebyp),
      .nxt_rcc_bdcr_lseon    (n_lseon),
      .cur_rcc_bdcr_bdrst    (c_bdrst),
      .cur_rcc_bdcr_rtcen    (c_rtcen),
      .cur_rcc_bdcr_rtcsel   (c_rtcsel),
      .cur_rcc_bdcr_lsecssd  (c_lsecssd),
      .cur_rcc_bdcr_lsecsson (c_lsecsson),
      .cur_rcc_bdcr_lsedrv   (c_lsedrv),
      .cur_rcc_bdcr_lsebyp   (c_lsebyp),
      .cur_rcc_bdcr_lserdy   (c_lserdy),
      .cur_rcc_bdcr_lseon    (c_lseon)
   );

   assign nxt_vec  = {n_bdrst, n_rtcen, n_rtcsel, n_lsecsson, n_lsedrv, n_lsebyp, n_lseon};
   assign wren_vec = {wren2, wren1, wren0};

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic wr, input logic [31:0] wd, input logic [3:0] be,
                       input logic [31:0] exp_rd, input logic exp_err, output int w);
      exp_q.push_back({exp_rd, exp_err});
      bus.req_valid = 1'b1;
      bus.req_write = wr;
      bus.req_wdata = wd;
      bus.req_be    = be;
      w = 0;
      while (!bus.req_ready && w < 50) begin
         tick();
         w++;
      end
      tick();
      bus.req_valid = 1'b0;
   endtask

   task automatic wait_rsp(output int l, output int c0, output int c1, output int c2,
                           output int f, output logic [8:0] nx);
      l = 1; c0 = 0; c1 = 0; c2 = 0; f = 0; nx = '0;
      while (!bus.rsp_valid && l < 20) begin
         c0 += int'(wren0);
         c1 += int'(wren1);
         c2 += int'(wren2);
         if (f == 0 && wren_vec != 3'b000) begin
            f  = l;
            nx = nxt_vec;
         end
         tick();
         l++;
      end
   endtask

   // Scoreboard: every response pops the oldest expected {rdata, err}.
   always @(negedge clk) begin
      if (rst_n && bus.rsp_valid) begin
         check("rsp_pending", 32'(exp_q.size() > 0), 32'd1);
         if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            check("rsp_rdata", bus.rsp_rdata, mon_e[32:1]);
            check("rsp_err", 32'(bus.rsp_err), 32'(mon_e[0]));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

   initial begin
      bus.req_valid = 1'b0;
      bus.req_write = 1'b0;
      bus.req_wdata = '0;
      bus.req_be    = '0;
      #1 rst_n = 1'b0;
      repeat (2) tick();
      check("rst_ready", 32'(bus.req_ready), 32'd1);
      check("rst_wren", 32'(wren_vec), 32'd0);
      check("rst_nxt", 32'(nxt_vec), 32'd0);
      check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      check("rst_rdata", bus.rsp_rdata, 32'd0);
      check("rst_err", 32'(bus.rsp_err), 32'd0);
      rst_n = 1'b1;
      tick();

      // Mixed-byte write: lseon, lsedrv, rtcen, rtcsel.
      dbp = 1'b1;
      send(1'b1, 32'h0000_8119, 4'b0011, 32'd0, 1'b0, waited);
      check("w1_wait", 32'(waited), 32'd0);
      wait_rsp(lat, n0, n1, n2, first, nr);
      check("w1_latency", 32'(lat), 32'd5);
      check("w1_first_pulse", 32'(first), 32'd2);
      check("w1_wren0_len", 32'(n0), 32'd2);
      check("w1_wren1_len", 32'(n1), 32'd2);
      check("w1_wren2_len", 32'(n2), 32'd0);
      check("w1_nxt_at_rise", 32'(nr), 32'h0AD);
      check("w1_nxt", 32'(nxt_vec), 32'h0AD);
      tick();

      // Protected write rejected.
      dbp = 1'b0;
      send(1'b1, 32'h0001_0000, 4'b0100, 32'd0, 1'b1, waited);
      wait_rsp(lat, n0, n1, n2, first, nr);
      check("w_dbp0_latency", 32'(lat), 32'd1);
      check("w_dbp0_err", 32'(bus.rsp_err), 32'd1);
      repeat (4) begin
         check("w_dbp0_no_wren", 32'(wren_vec), 32'd0);
         tick();
      end
      check("w_dbp0_nxt", 32'(nxt_vec), 32'h0AD);

      // lsedrv frozen while LSE is on.
      dbp = 1'b1; c_lseon = 1'b1; c_lsedrv = 2'b00;
      send(1'b1, 32'h0000_0019, 4'b0001, 32'd0, 1'b0, waited);
      wait_rsp(lat, n0, n1, n2, first, nr);
      check("lsedrv_lock_latency", 32'(lat), 32'd5);
      check("lsedrv_lock_val", 32'(n_lsedrv), 32'd0);
      check("lsedrv_lock_nxt", 32'(nxt_vec), 32'h001);
      check("lsedrv_lock_wren", 32'({n2 != 0, n1 != 0, n0 == 2}), 32'b001);
      tick();

      // lsecsson is write-1-to-set.
      c_lseon = 1'b0; c_lsecsson = 1'b1;
      send(1'b1, 32'h0000_0000, 4'b0001, 32'd0, 1'b0, waited);
      wait_rsp(lat, n0, n1, n2, first, nr);
      check("w1s_lsecsson", 32'(n_lsecsson), 32'd1);
      check("w1s_nxt", 32'(nxt_vec), 32'h010);
      tick();

      // Write with no mapped byte enabled.
      send(1'b1, 32'hFFFF_FFFF, 4'b1000, 32'd0, 1'b0, waited);
      wait_rsp(lat, n0, n1, n2, first, nr);
      check("be_none_latency", 32'(lat), 32'd1);
      repeat (4) begin
         check("be_none_no_wren", 32'(wren_vec), 32'd0);
         tick();
      end
      check("be_none_nxt", 32'(nxt_vec), 32'h010);

      // Reads: partial and full images.
      c_lsecsson = 1'b0; c_lserdy = 1'b1; c_lsecssd = 1'b1; c_rtcsel = 2'b10;
      send(1'b0, 32'd0, 4'b1111, 32'h0000_0242, 1'b0, waited);
      wait_rsp(lat, n0, n1, n2, first, nr);
      check("rd1_latency", 32'(lat), 32'd1);
      tick();
      c_bdrst = 1'b1; c_rtcen = 1'b1; c_rtcsel = 2'b11; c_lsecsson = 1'b1;
      c_lsedrv = 2'b11; c_lsebyp = 1'b1; c_lseon = 1'b1;
      dbp = 1'b0;
      send(1'b0, 32'd0, 4'b0000, 32'h0001_837F, 1'b0, waited);
      wait_rsp(lat, n0, n1, n2, first, nr);
      check("rd2_latency", 32'(lat), 32'd1);
      tick();
      {c_bdrst, c_rtcen, c_rtcsel, c_lsecssd, c_lsecsson, c_lsedrv, c_lsebyp, c_lserdy, c_lseon} = '0;

      // Byte 2 only.
      dbp = 1'b1;
      send(1'b1, 32'h0001_0000, 4'b0100, 32'd0, 1'b0, waited);
      wait_rsp(lat, n0, n1, n2, first, nr);
      check("bdrst_wren", 32'({n2, n1, n0}), {8'd2, 24'd0} >> 0 == 32'd0 ? 32'd0 : 32'({32'd2, 32'd0, 32'd0}));
      check("bdrst_nxt", 32'(nxt_vec), 32'h100);
      tick();

      // dbp drops after accept: write still completes.
      send(1'b1, 32'h0000_0000, 4'b0100, 32'd0, 1'b0, waited);
      dbp = 1'b0;
      wait_rsp(lat, n0, n1, n2, first, nr);
      check("dbp_drop_latency", 32'(lat), 32'd5);
      check("dbp_drop_wren2", 32'(n2), 32'd2);
      check("dbp_drop_nxt", 32'(nxt_vec), 32'h000);
      tick();

      // Back-to-back: second request waits for ready.
      dbp = 1'b1;
      send(1'b1, 32'h0000_0001, 4'b0001, 32'd0, 1'b0, waited);
      c_rtcen = 1'b1;
      send(1'b0, 32'd0, 4'b0000, 32'h0000_8000, 1'b0, waited);
      check("b2b_wait", 32'(waited), 32'd4);
      check("b2b_rd_valid", 32'(bus.rsp_valid), 32'd1);
      check("b2b_nxt", 32'(nxt_vec), 32'h001);
      c_rtcen = 1'b0;
      tick();

      // Reset during PULSE aborts without a response.
      send(1'b1, 32'h0000_0001, 4'b0001, 32'd0, 1'b0, waited);
      tick();
      check("abort_wren_hi", 32'(wren0), 32'd1);
      rst_n = 1'b0;
      #1;
      check("abort_wren_lo", 32'(wren_vec), 32'd0);
      check("abort_ready", 32'(bus.req_ready), 32'd1);
      void'(exp_q.pop_back());
      tick();
      rst_n = 1'b1;
      rsp_cnt = 0;
      repeat (8) begin
         tick();
         rsp_cnt += int'(bus.rsp_valid);
      end
      check("abort_no_rsp", 32'(rsp_cnt), 32'd0);
      check("abort_nxt", 32'(nxt_vec), 32'd0);
      check("abort_wren_idle", 32'(wren_vec), 32'd0);

      check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
